fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_next_pc.sv | 69 ++++++
 rtl/fetch_unit.sv | 90 +++++++++
 tb/tb_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2,
      FAULT  = 2'd3
   } fetch_state_t;

   localparam logic [31:0] EBREAK_INSN      = 32'h0010_0073;
   localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-pc / next-state selection for the fetch stage.
// With FETCH_MISALIGN_TRAP_EN defined, a misaligned redirect enters FAULT instead of loading pc.
module fetch_next_pc
   import fetch_pkg::*;
(
   input  logic [1:0]  state_i,
   input  logic [31:0] pc_i,
   input  logic        stall_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_target_i,
   input  logic        resume_i,
   input  logic [31:0] imem_data_i,
   output logic [1:0]  state_d_o,
   output logic [31:0] pc_d_o,
   output logic        count_inc_o,
   output logic        fault_set_o
);

   fetch_state_t state;
   fetch_state_t state_d;

   assign state     = fetch_state_t'(state_i);
   assign state_d_o = state_d;

   always_comb begin
      state_d     = state;
      pc_d_o      = pc_i;
      count_inc_o = 1'b0;
      fault_set_o = 1'b0;
      case (state)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            // A stalled cycle consumes nothing; execute re-asserts any redirect.
            if (!stall_i) begin
               count_inc_o = 1'b1;
               if (imem_data_i == EBREAK_INSN) begin
                  state_d = HALTED;
               end else if (redirect_valid_i) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                  if (redirect_target_i[1:0] != 2'b00) begin
                     state_d     = FAULT;
                     fault_set_o = 1'b1;
                     count_inc_o = 1'b0;
                  end else begin
                     pc_d_o = redirect_target_i;
                  end
`else
                  pc_d_o = redirect_target_i & 32'hFFFF_FFFC;
`endif
               end else begin
                  pc_d_o = pc_i + 32'd4;
               end
            end
         end
         HALTED: begin
            if (resume_i) begin
               pc_d_o  = pc_i + 32'd4;
               state_d = RUN;
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC/state registers, fetched-instruction counter, decode-facing outputs.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets into FAULT.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int          ADDR_WIDTH = 10,
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall_i,
   input  logic                  redirect_valid_i,
   input  logic [31:0]           redirect_target_i,
   input  logic                  resume_i,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   input  logic [31:0]           imem_data_i,
   output logic [31:0]           instr_o,
   output logic [31:0]           pc_o,
   output logic                  instr_valid_o,
   output logic                  halted_o,
   output logic                  fault_o,
   output logic [31:0]           fault_addr_o,
   output logic [31:0]           instr_count_o
);

   logic [1:0]  state_q;
   logic [1:0]  state_d;
   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] count_q;
   logic        count_inc;
   logic        fault_set;

   fetch_next_pc u_next_pc (
      .state_i           (state_q),
      .pc_i              (pc_q),
      .stall_i           (stall_i),
      .redirect_valid_i  (redirect_valid_i),
      .redirect_target_i (redirect_target_i),
      .resume_i          (resume_i),
      .imem_data_i       (imem_data_i),
      .state_d_o         (state_d),
      .pc_d_o            (pc_d),
      .count_inc_o       (count_inc),
      .fault_set_o       (fault_set)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         count_q <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         if (count_inc) begin
            count_q <= count_q + 32'd1;
         end
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   logic [31:0] fault_addr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault_addr_q <= 32'd0;
      end else if (fault_set) begin
         fault_addr_q <= redirect_target_i;
      end
   end

   assign fault_o      = (state_q == FAULT);
   assign fault_addr_o = fault_addr_q;
`else
   // FAULT is unreachable without the trap, so the capture path is absent.
   logic unused_fault_set;
   assign unused_fault_set = fault_set;
   assign fault_o          = 1'b0;
   assign fault_addr_o     = 32'd0;
`endif

   assign imem_addr_o   = pc_q[ADDR_WIDTH-1:0];
   assign pc_o          = pc_q;
   assign instr_valid_o = (state_q == RUN);
   assign instr_o       = instr_valid_o ? imem_data_i : NOP_INSN;
   assign halted_o      = (state_q == HALTED);
   assign instr_count_o = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a combinational ROM model.
module tb_fetch_unit;

   localparam int          AW     = 10;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic          clk;
   logic          rst;
   logic          stall_i;
   logic          redirect_valid_i;
   logic [31:0]   redirect_target_i;
   logic          resume_i;
   logic [AW-1:0] imem_addr_o;
   logic [31:0]   imem_data_i;
   logic [31:0]   instr_o;
   logic [31:0]   pc_o;
   logic          instr_valid_o;
   logic          halted_o;
   logic          fault_o;
   logic [31:0]   fault_addr_o;
   logic [31:0]   instr_count_o;

   int          n_cmp;
   int          n_err;
   logic [31:0] exp_cnt;
   logic        ebreak_on;
   logic [31:0] ebreak_addr;

   fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
      .clk               (clk),
      .rst               (rst),
      .stall_i           (stall_i),
      .redirect_valid_i  (redirect_valid_i),
      .redirect_target_i (redirect_target_i),
      .resume_i          (resume_i),
      .imem_addr_o       (imem_addr_o),
      .imem_data_i       (imem_data_i),
      .instr_o           (instr_o),
      .pc_o              (pc_o),
      .instr_valid_o     (instr_valid_o),
      .halted_o          (halted_o),
      .fault_o           (fault_o),
      .fault_addr_o      (fault_addr_o),
      .instr_count_o     (instr_count_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM: each word is an ADDI tagged with its address, never an EBREAK unless planted.
   always_comb begin
      if (ebreak_on && ({22'd0, imem_addr_o} == (ebreak_addr & 32'h3FF)))
         imem_data_i = EBREAK;
      else
         imem_data_i = NOP | ({22'd0, imem_addr_o} << 20);
   end

   function automatic logic [31:0] rom_word(input logic [31:0] pc);
      return NOP | ((pc & 32'h3FF) << 20);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_cmp++; if (pc_o !== 32'h0) begin n_err++; $display("FAIL rst_pc got %h exp %h", pc_o, 32'h0); end
      n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", instr_valid_o); end
      n_cmp++; if (instr_o !== NOP) begin n_err++; $display("FAIL rst_instr got %h exp %h", instr_o, NOP); end
      n_cmp++; if ({halted_o, fault_o} !== 2'b00) begin n_err++; $display("FAIL rst_flags got %b exp 00", {halted_o, fault_o}); end
      n_cmp++; if (instr_count_o !== 32'h0) begin n_err++; $display("FAIL rst_count got %h exp 0", instr_count_o); end
      n_cmp++; if (fault_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_fault_addr got %h exp 0", fault_addr_o); end
      rst = 1'b0;
      #1;
      n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL boot_valid got %b exp 0", instr_valid_o); end
      exp_cnt = 32'd0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (pc_o !== 32'(i * 4)) begin n_err++; $display("FAIL run_pc[%0d] got %h exp %h", i, pc_o, 32'(i * 4)); end
         n_cmp++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL run_valid[%0d] got %b exp 1", i, instr_valid_o); end
         n_cmp++; if (instr_o !== rom_word(32'(i * 4))) begin n_err++; $display("FAIL run_instr[%0d] got %h exp %h", i, instr_o, rom_word(32'(i * 4))); end
         n_cmp++; if (instr_count_o !== exp_cnt) begin n_err++; $display("FAIL run_count[%0d] got %h exp %h", i, instr_count_o, exp_cnt); end
         exp_cnt++;
      end
      exp_cnt = 32'd2;
   endtask

   task automatic test_stall();
      stall_i = 1'b1;
      redirect_valid_i = 1'b1;
      redirect_target_i = 32'h40;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++; if (pc_o !== 32'h8) begin n_err++; $display("FAIL stall_pc[%0d] got %h exp 00000008", i, pc_o); end
         n_cmp++; if (instr_count_o !== exp_cnt) begin n_err++; $display("FAIL stall_count[%0d] got %h exp %h", i, instr_count_o, exp_cnt); end
      end
      stall_i = 1'b0;
      tick();
      exp_cnt++;
      redirect_valid_i = 1'b0;
      n_cmp++; if (pc_o !== 32'h40) begin n_err++; $display("FAIL stall_release_pc got %h exp 00000040", pc_o); end
      n_cmp++; if (instr_count_o !== exp_cnt) begin n_err++; $display("FAIL stall_release_count got %h exp %h", instr_count_o, exp_cnt); end
   endtask

   task automatic test_ebreak();
      ebreak_on = 1'b1;
      ebreak_addr = 32'h10;
      redirect_valid_i = 1'b1;
      redirect_target_i = 32'h10;
      tick();
      exp_cnt++;
      redirect_valid_i = 1'b0;
      n_cmp++; if (instr_o !== EBREAK) begin n_err++; $display("FAIL ebreak_instr got %h exp %h", instr_o, EBREAK); end
      tick();
      exp_cnt++;
      stall_i = 1'b1;
      redirect_valid_i = 1'b1;
      redirect_target_i = 32'h80;
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (halted_o !== 1'b1) begin n_err++; $display("FAIL halt_flag[%0d] got %b exp 1", i, halted_o); end
         n_cmp++; if (pc_o !== 32'h10) begin n_err++; $display("FAIL halt_pc[%0d] got %h exp 00000010", i, pc_o); end
         n_cmp++; if ({instr_valid_o, instr_o} !== {1'b0, NOP}) begin n_err++; $display("FAIL halt_out[%0d] got %b/%h exp 0/%h", i, instr_valid_o, instr_o, NOP); end
         n_cmp++; if (instr_count_o !== exp_cnt) begin n_err++; $display("FAIL halt_count[%0d] got %h exp %h", i, instr_count_o, exp_cnt); end
         tick();
      end
      stall_i = 1'b0;
      redirect_valid_i = 1'b0;
      resume_i = 1'b1;
      tick();
      resume_i = 1'b0;
      n_cmp++; if (pc_o !== 32'h14) begin n_err++; $display("FAIL resume_pc got %h exp 00000014", pc_o); end
      n_cmp++; if ({instr_valid_o, halted_o} !== 2'b10) begin n_err++; $display("FAIL resume_flags got %b exp 10", {instr_valid_o, halted_o}); end
      n_cmp++; if (instr_o !== rom_word(32'h14)) begin n_err++; $display("FAIL resume_instr got %h exp %h", instr_o, rom_word(32'h14)); end
      n_cmp++; if (instr_count_o !== exp_cnt) begin n_err++; $display("FAIL resume_count got %h exp %h", instr_count_o, exp_cnt); end
   endtask

   task automatic test_ebreak_redirect();
      redirect_valid_i = 1'b1;
      redirect_target_i = 32'h10;
      tick();
      exp_cnt++;
      redirect_target_i = 32'h200;
      tick();
      exp_cnt++;
      redirect_valid_i = 1'b0;
      n_cmp++; if ({halted_o, pc_o} !== {1'b1, 32'h10}) begin n_err++; $display("FAIL ebrk_redir got %b/%h exp 1/00000010", halted_o, pc_o); end
      n_cmp++; if (instr_count_o !== exp_cnt) begin n_err++; $display("FAIL ebrk_redir_count got %h exp %h", instr_count_o, exp_cnt); end
      resume_i = 1'b1;
      tick();
      resume_i = 1'b0;
      ebreak_on = 1'b0;
      n_cmp++; if (pc_o !== 32'h14) begin n_err++; $display("FAIL ebrk_redir_resume got %h exp 00000014", pc_o); end
   endtask

   task automatic test_wrap();
      redirect_valid_i = 1'b1;
      redirect_target_i = 32'hFFFF_FFFC;
      tick();
      exp_cnt++;
      redirect_valid_i = 1'b0;
      n_cmp++; if (imem_addr_o !== 10'h3FC) begin n_err++; $display("FAIL wrap_addr_hi got %h exp 3fc", imem_addr_o); end
      tick();
      exp_cnt++;
      n_cmp++; if (pc_o !== 32'h0) begin n_err++; $display("FAIL wrap_pc got %h exp 00000000", pc_o); end
      n_cmp++; if (imem_addr_o !== 10'h0) begin n_err++; $display("FAIL wrap_addr got %h exp 000", imem_addr_o); end
      n_cmp++; if (instr_count_o !== exp_cnt) begin n_err++; $display("FAIL wrap_count got %h exp %h", instr_count_o, exp_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] tgt [3];
      tgt[0] = 32'h100;
      tgt[1] = 32'h204;
      tgt[2] = 32'h308;
      redirect_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         redirect_target_i = tgt[i];
         tick();
         exp_cnt++;
         n_cmp++; if (pc_o !== tgt[i]) begin n_err++; $display("FAIL b2b_pc[%0d] got %h exp %h", i, pc_o, tgt[i]); end
      end
      redirect_valid_i = 1'b0;
      tick();
      exp_cnt++;
      n_cmp++; if (pc_o !== 32'h30C) begin n_err++; $display("FAIL b2b_inc got %h exp 0000030c", pc_o); end
      n_cmp++; if (instr_count_o !== exp_cnt) begin n_err++; $display("FAIL b2b_count got %h exp %h", instr_count_o, exp_cnt); end
   endtask

   task automatic test_reset_halted();
      ebreak_on = 1'b1;
      ebreak_addr = 32'h10;
      redirect_valid_i = 1'b1;
      redirect_target_i = 32'h10;
      tick();
      redirect_valid_i = 1'b0;
      tick();
      n_cmp++; if (halted_o !== 1'b1) begin n_err++; $display("FAIL pre_rst_halt got %b exp 1", halted_o); end
      rst = 1'b1;
      #1;
      n_cmp++; if ({halted_o, instr_valid_o, fault_o} !== 3'b000) begin n_err++; $display("FAIL mid_rst_flags got %b exp 000", {halted_o, instr_valid_o, fault_o}); end
      n_cmp++; if (pc_o !== 32'h0) begin n_err++; $display("FAIL mid_rst_pc got %h exp 0", pc_o); end
      n_cmp++; if (instr_count_o !== 32'h0) begin n_err++; $display("FAIL mid_rst_count got %h exp 0", instr_count_o); end
      n_cmp++; if (instr_o !== NOP) begin n_err++; $display("FAIL mid_rst_instr got %h exp %h", instr_o, NOP); end
      tick();
      rst = 1'b0;
      ebreak_on = 1'b0;
      #1;
      n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL re_boot_valid got %b exp 0", instr_valid_o); end
      tick();
      n_cmp++; if ({instr_valid_o, pc_o} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL re_run got %b/%h exp 1/00000000", instr_valid_o, pc_o); end
      tick();
      exp_cnt = 32'd1;
      n_cmp++; if ({pc_o, instr_count_o} !== {32'h4, exp_cnt}) begin n_err++; $display("FAIL re_run2 got %h/%h exp 00000004/%h", pc_o, instr_count_o, exp_cnt); end
   endtask

   task automatic test_misalign();
      redirect_valid_i = 1'b1;
      redirect_target_i = 32'h22;
      tick();
      redirect_valid_i = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      for (int i = 0; i < 2; i++) begin
         n_cmp++; if ({fault_o, instr_valid_o} !== 2'b10) begin n_err++; $display("FAIL mis_flags[%0d] got %b exp 10", i, {fault_o, instr_valid_o}); end
         n_cmp++; if (fault_addr_o !== 32'h22) begin n_err++; $display("FAIL mis_fault_addr[%0d] got %h exp 00000022", i, fault_addr_o); end
         n_cmp++; if (pc_o !== 32'h4) begin n_err++; $display("FAIL mis_pc[%0d] got %h exp 00000004", i, pc_o); end
         n_cmp++; if (instr_count_o !== exp_cnt) begin n_err++; $display("FAIL mis_count[%0d] got %h exp %h", i, instr_count_o, exp_cnt); end
         tick();
      end
`else
      exp_cnt++;
      n_cmp++; if (pc_o !== 32'h20) begin n_err++; $display("FAIL mis_pc got %h exp 00000020", pc_o); end
      n_cmp++; if ({fault_o, fault_addr_o} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL mis_fault got %b/%h exp 0/0", fault_o, fault_addr_o); end
      n_cmp++; if (instr_count_o !== exp_cnt) begin n_err++; $display("FAIL mis_count got %h exp %h", instr_count_o, exp_cnt); end
      tick();
      n_cmp++; if (pc_o !== 32'h24) begin n_err++; $display("FAIL mis_next_pc got %h exp 00000024", pc_o); end
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      exp_cnt = 32'd0;
      rst = 1'b1;
      stall_i = 1'b0;
      redirect_valid_i = 1'b0;
      redirect_target_i = 32'h0;
      resume_i = 1'b0;
      ebreak_on = 1'b0;
      ebreak_addr = 32'h0;
      test_reset();
      test_stall();
      test_ebreak();
      test_ebreak_redirect();
      test_wrap();
      test_back_to_back();
      test_reset_halted();
      test_misalign();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
